// File: rtl/fp_add_normalizer.sv
// Normalize, round (RNE) and pack stage of a single-precision FP adder.
// Define NORM_LZC_EN to replace the bit-serial left shift with a one-cycle leading-zero-count shift.
module fp_add_normalizer #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sign_in,
  input  logic [EXP_W-1:0]          exp_in,
  input  logic [FRAC_W+3:0]         mant_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic                      overflow,
  output logic                      zero
);

  localparam int SIG_W = FRAC_W + 1;  // {hidden, frac}
  localparam int MW    = FRAC_W + 3;  // {hidden, frac, guard, sticky}
  localparam logic [EXP_W:0] ONE     = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t           state;
  logic             sign_r;
  logic [EXP_W:0]   exp_r;   // one spare bit so exponent overflow stays visible
  logic [MW-1:0]    mant_r;
  logic             zero_pend;
  logic             subn;

  // A carry-out at load is absorbed by a right shift; the dropped guard folds into sticky.
  logic [MW-1:0]    mant_load;
  logic [EXP_W:0]   exp_load;
  always_comb begin
    mant_load = mant_in[MW-1:0];
    exp_load  = {1'b0, exp_in};
    if (mant_in[FRAC_W+3]) begin
      mant_load = {mant_in[FRAC_W+3:2], mant_in[1] | mant_in[0]};
      exp_load  = {1'b0, exp_in} + ONE;
    end
  end

  // Round-to-nearest-even on the normalized significand.
  logic [SIG_W-1:0]  sig;
  logic              round_up;
  logic [SIG_W:0]    sum;
  logic [FRAC_W-1:0] frac_rnd;
  logic [EXP_W:0]    exp_rnd;
  always_comb begin
    sig      = mant_r[MW-1:2];
    round_up = mant_r[1] & (mant_r[0] | sig[0]);
    sum      = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};
    frac_rnd = sum[SIG_W] ? sum[SIG_W-1:1] : sum[FRAC_W-1:0];
    if (subn)
      exp_rnd = sum[FRAC_W] ? ONE : '0;
    else
      exp_rnd = exp_r + {{EXP_W{1'b0}}, sum[SIG_W]};
  end

`ifdef NORM_LZC_EN
  localparam int LZ_W = SIG_W + 1;  // guard included so a guard-only value normalizes too
  logic [LZ_W-1:0] lz_vec;
  logic [LZ_W-1:0] lz_shifted;
  logic [EXP_W:0]  lzc;
  logic [EXP_W:0]  shift_amt;
  logic            lz_found;
  always_comb begin
    lz_vec   = mant_r[MW-1:1];
    lzc      = '0;
    lz_found = 1'b0;
    for (int i = LZ_W - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (lz_vec[i]) lz_found = 1'b1;
        else           lzc      = lzc + ONE;
      end
    end
    // Clamp so the exponent never drops below 1; a remaining zero hidden bit means subnormal.
    shift_amt  = (lzc < exp_r - ONE) ? lzc : exp_r - ONE;
    lz_shifted = lz_vec << shift_amt;
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: every register here is state, so only non-blocking assignments are used;
    // the datapath registers are reset too so no X ever reaches result.
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      mant_r    <= '0;
      zero_pend <= 1'b0;
      subn      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r    <= sign_in;
            exp_r     <= exp_load;
            mant_r    <= mant_load;
            zero_pend <= 1'b0;
            subn      <= 1'b0;
            in_ready  <= 1'b0;
            state     <= NORM;
          end
        end
        NORM: begin
          if (mant_r == '0) begin
            zero_pend <= 1'b1;
            state     <= ROUND;
          end else begin
`ifdef NORM_LZC_EN
            mant_r <= {lz_shifted, mant_r[0]};
            exp_r  <= exp_r - shift_amt;
            subn   <= ~lz_shifted[LZ_W-1];
            state  <= ROUND;
`else
            if (!mant_r[MW-1] && exp_r > ONE) begin
              mant_r <= {mant_r[MW-2:1], 1'b0, mant_r[0]};
              exp_r  <= exp_r - ONE;
            end else begin
              subn  <= ~mant_r[MW-1];
              state <= ROUND;
            end
`endif
          end
        end
        ROUND: begin
          if (zero_pend) begin
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
          end else if (exp_rnd >= EXP_MAX) begin
            result   <= {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            overflow <= 1'b1;
            zero     <= 1'b0;
          end else begin
            result   <= {sign_r, exp_rnd[EXP_W-1:0], frac_rnd};
            overflow <= 1'b0;
            zero     <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Directed self-checking bench for fp_add_normalizer; latency expectations follow NORM_LZC_EN.
module tb_fp_add_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [26:0] mant_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        zero;

  int errors = 0;
  int checks = 0;

  fp_add_normalizer #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic int lat(input int k);
`ifdef NORM_LZC_EN
    return 3;
`else
    return 3 + k;
`endif
  endfunction

  // mant_in layout: {carry, hidden, frac[22:0], guard, sticky}
  function automatic logic [26:0] mk(input logic c, input logic h, input logic [22:0] f,
                                     input logic g, input logic s);
    return {c, h, f, g, s};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; mant_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== 32'h0)   begin errors++; $display("FAIL reset_result got=%h want=00000000", result); end
    checks++; if ({overflow, zero} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b want=00", overflow, zero); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issues one operation, checks latency/result/flags, then completes the output handshake.
  task automatic run_op(input string name, input logic s, input logic [7:0] e, input logic [26:0] m,
                        input logic [31:0] exp_res, input logic exp_ovf, input logic exp_zero,
                        input int exp_lat);
    int cyc;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got=%b want=1", name, in_ready); end
    sign_in = s; exp_in = e; mant_in = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sign_in = ~s; exp_in = 8'h55; mant_in = 27'h5a5a5a5;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    checks++; if (cyc !== exp_lat) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, exp_lat); end
    checks++; if (result !== exp_res) begin errors++; $display("FAIL %s_result got=%h want=%h", name, result, exp_res); end
    checks++; if ({overflow, zero} !== {exp_ovf, exp_zero})
      begin errors++; $display("FAIL %s_flags ovf/zero got=%b%b want=%b%b", name, overflow, zero, exp_ovf, exp_zero); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_busy got=%b want=0", name, in_ready); end
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready} !== 2'b01)
      begin errors++; $display("FAIL %s_accept valid/ready got=%b%b want=01", name, out_valid, in_ready); end
  endtask

  task automatic test_basic();
    run_op("one",      1'b0, 8'd127, mk(0, 1, 23'h0, 0, 0), 32'h3F800000, 0, 0, lat(0));
    run_op("carry",    1'b0, 8'd127, mk(1, 0, 23'h0, 0, 0), 32'h40000000, 0, 0, lat(0));
    run_op("shift3",   1'b0, 8'd130, mk(0, 0, 23'h100000, 0, 0), 32'h3F800000, 0, 0, lat(3));
    run_op("shift24",  1'b0, 8'd200, mk(0, 0, 23'h0, 1, 0), 32'h58000000, 0, 0, lat(24));
  endtask

  task automatic test_rounding();
    run_op("tie_up_ovf", 1'b0, 8'd127, mk(0, 1, 23'h7FFFFF, 1, 0), 32'h40000000, 0, 0, lat(0));
    run_op("tie_even",   1'b1, 8'd127, mk(0, 1, 23'h000002, 1, 0), 32'hBF800002, 0, 0, lat(0));
    run_op("above_half", 1'b0, 8'd127, mk(0, 1, 23'h000002, 1, 1), 32'h3F800003, 0, 0, lat(0));
  endtask

  task automatic test_special();
    run_op("ovf_carry",  1'b0, 8'd254, mk(1, 0, 23'h0, 0, 0), 32'h7F800000, 1, 0, lat(0));
    run_op("ovf_round",  1'b1, 8'd254, mk(0, 1, 23'h7FFFFF, 1, 1), 32'hFF800000, 1, 0, lat(0));
    run_op("zero",       1'b1, 8'd100, 27'h0, 32'h00000000, 0, 1, lat(0));
    run_op("subnormal",  1'b0, 8'd2,   mk(0, 0, 23'h200000, 0, 0), 32'h00400000, 0, 0, lat(1));
    run_op("subn_round", 1'b0, 8'd1,   mk(0, 0, 23'h7FFFFF, 1, 1), 32'h00800000, 0, 0, lat(0));
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    sign_in = 1'b0; exp_in = 8'd128; mant_in = mk(0, 1, 23'h400000, 0, 0); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({out_valid, in_ready, result} !== {2'b10, 32'h40400000})
        begin errors++; $display("FAIL bp_hold%0d valid/ready/result got=%b%b/%h want=10/40400000", i, out_valid, in_ready, result); end
      in_valid = 1'b1;  // must not be accepted while busy
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready} !== 2'b01)
      begin errors++; $display("FAIL bp_release valid/ready got=%b%b want=01", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_norm();
    sign_in = 1'b0; exp_in = 8'd130; mant_in = mk(0, 0, 23'h100000, 0, 0); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01)
      begin errors++; $display("FAIL midrst valid/ready got=%b%b want=01", out_valid, in_ready); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_a", 1'b0, 8'd127, mk(0, 1, 23'h0, 0, 0), 32'h3F800000, 0, 0, lat(0));
    run_op("b2b_b", 1'b1, 8'd128, mk(0, 1, 23'h400000, 0, 0), 32'hC0400000, 0, 0, lat(0));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
